trigger_sequencer: RTL and testbench

- Sequences the logic analyzer's parallel trigger stages; owns the current trigger level.
- Each cycle it enables the stages whose configured level is reached and collects their match flags.
- On a match it either advances the level or, for a start stage, counts the configured delay and then issues the capture-start pulse to the sampler/memory controller.
- Sits between the trigger stage array and the capture controller; configuration comes from the command decoder registers.

---
 rtl/trigger_sequencer_if.sv | 29 ++
 rtl/trigger_sequencer.sv | 101 ++++++++++
 tb/tb_trigger_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_if.sv
// Bundles the stage-array, decoder config and capture-controller signals of the trigger sequencer.
// The master side drives commands, samples and configuration; the slave side is the sequencer itself.
interface trigger_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int LEVEL_W    = 2,
    parameter int DELAY_W    = 16
);
    logic                          arm_i;
    logic                          smpl_valid_i;
    logic [NUM_STAGES-1:0]         stg_match_i;
    logic [NUM_STAGES-1:0]         stg_start_i;
    logic [NUM_STAGES*LEVEL_W-1:0] stg_level_i;
    logic [NUM_STAGES*DELAY_W-1:0] stg_delay_i;
    logic [NUM_STAGES-1:0]         stg_active_o;
    logic [LEVEL_W-1:0]            level_o;
    logic                          armed_o;
    logic                          run_o;
    logic                          triggered_o;

    modport master (
        output arm_i, smpl_valid_i, stg_match_i, stg_start_i, stg_level_i, stg_delay_i,
        input  stg_active_o, level_o, armed_o, run_o, triggered_o
    );

    modport slave (
        input  arm_i, smpl_valid_i, stg_match_i, stg_start_i, stg_level_i, stg_delay_i,
        output stg_active_o, level_o, armed_o, run_o, triggered_o
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Trigger level sequencer: enables stages by level, advances the level on matches, and
// issues a one-cycle capture-start pulse after an optional per-stage delay in valid samples.
module trigger_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int LEVEL_W    = 2,
    parameter int DELAY_W    = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    trigger_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_FIRED = 2'd3;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    logic [1:0]            r_state;
    logic [LEVEL_W-1:0]    r_level;
    logic [DELAY_W-1:0]    r_count;
    logic                  r_run;

    logic [NUM_STAGES-1:0] w_active;
    logic [NUM_STAGES-1:0] w_qual;
    logic [NUM_STAGES-1:0] w_startHit;
    logic [DELAY_W-1:0]    w_startDelay;

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_active[i] = (r_state == ST_ARMED) &&
                          (r_level >= bus.stg_level_i[i*LEVEL_W +: LEVEL_W]);
        end
    end

    assign w_qual     = w_active & bus.stg_match_i & {NUM_STAGES{bus.smpl_valid_i}};
    assign w_startHit = w_qual & bus.stg_start_i;

    // Walking from the top down lets the lowest-index start stage win.
    always_comb begin
        w_startDelay = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (w_startHit[i]) begin
                w_startDelay = bus.stg_delay_i[i*DELAY_W +: DELAY_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_level <= '0;
            r_count <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b0;
            if (bus.arm_i) begin
                r_state <= ST_ARMED;
                r_level <= '0;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_ARMED: begin
                        if (|w_startHit) begin
                            if (w_startDelay == '0) begin
                                r_state <= ST_FIRED;
                                r_run   <= 1'b1;
                            end else begin
                                r_state <= ST_DELAY;
                                r_count <= w_startDelay;
                            end
                        end else if ((|w_qual) && (r_level != LEVEL_MAX)) begin
                            r_level <= r_level + LEVEL_W'(1);
                        end
                    end
                    ST_DELAY: begin
                        // Counter is never zero here: it is loaded only with a nonzero delay.
                        if (bus.smpl_valid_i) begin
                            if (r_count == DELAY_W'(1)) begin
                                r_state <= ST_FIRED;
                                r_run   <= 1'b1;
                                r_count <= '0;
                            end else begin
                                r_count <= r_count - DELAY_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.stg_active_o = w_active;
    assign bus.level_o      = r_level;
    assign bus.armed_o      = (r_state == ST_ARMED) || (r_state == ST_DELAY);
    assign bus.triggered_o  = (r_state == ST_FIRED);
    assign bus.run_o        = r_run;
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: stimulus pushes expected status snapshots and run pulse
// cycles into queues, and a negedge monitor pops and compares them against the DUT.
module tb_trigger_sequencer;
    logic clk_i = 1'b0;
    logic rst_i;

    trigger_sequencer_if #(.NUM_STAGES(4), .LEVEL_W(2), .DELAY_W(16)) bus ();

    trigger_sequencer #(.NUM_STAGES(4), .LEVEL_W(2), .DELAY_W(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] level;
        logic       armed;
        logic [3:0] active;
        logic       trig;
    } status_t;

    status_t statusQ[$];
    string   nameQ[$];
    int      runQ[$];
    int      cycle = 0;
    int      vectors = 0;
    int      miscompares = 0;

    always @(posedge clk_i) cycle <= cycle + 1;

    // Monitor: compares any pending status snapshot and every run pulse seen.
    always @(negedge clk_i) begin
        status_t act;
        status_t exp;
        string   nm;
        int      expCycle;
        if (statusQ.size() > 0) begin
            exp = statusQ.pop_front();
            nm  = nameQ.pop_front();
            act = '{level: bus.level_o, armed: bus.armed_o, active: bus.stg_active_o,
                    trig: bus.triggered_o};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("[TB] FAIL %s: got level=%0d armed=%0b active=%04b trig=%0b, want level=%0d armed=%0b active=%04b trig=%0b",
                         nm, act.level, act.armed, act.active, act.trig,
                         exp.level, exp.armed, exp.active, exp.trig);
            end
        end
        if (bus.run_o === 1'b1) begin
            vectors++;
            if (runQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL run_unexpected: got run_o=1 at cycle %0d, want no pulse", cycle);
            end else begin
                expCycle = runQ.pop_front();
                if (expCycle != cycle) begin
                    miscompares++;
                    $display("[TB] FAIL run_timing: got pulse at cycle %0d, want cycle %0d", cycle, expCycle);
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic arm, input logic valid,
                                 input logic [3:0] match);
        rst_i            = rst;
        bus.arm_i        = arm;
        bus.smpl_valid_i = valid;
        bus.stg_match_i  = match;
        @(posedge clk_i);
        #1;
        rst_i            = 1'b0;
        bus.arm_i        = 1'b0;
        bus.smpl_valid_i = 1'b0;
        bus.stg_match_i  = '0;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] level, input logic armed,
                               input logic [3:0] active, input logic trig);
        statusQ.push_back('{level: level, armed: armed, active: active, trig: trig});
        nameQ.push_back(name);
    endtask

    task automatic expectRunNextEdge();
        runQ.push_back(cycle + 1);
    endtask

    task automatic configure(input logic [3:0] start, input logic [7:0] levels,
                             input logic [63:0] delays);
        bus.stg_start_i = start;
        bus.stg_level_i = levels;
        bus.stg_delay_i = delays;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i            = 1'b1;
        bus.arm_i        = 1'b1;
        bus.smpl_valid_i = 1'b0;
        bus.stg_match_i  = '0;
        configure(4'b1000, {2'd3, 2'd2, 2'd1, 2'd0}, 64'd0);
        #1;

        // Reset dominates a simultaneous arm.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("reset_state", 2'd0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("idle_after_reset", 2'd0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("armed_level0", 2'd0, 1'b1, 4'b0001, 1'b0);

        // Level advance through stages 0..2, stage 3 starts capture with no delay.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        checkOutput("advance_l1", 2'd1, 1'b1, 4'b0011, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        checkOutput("advance_l2", 2'd2, 1'b1, 4'b0111, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100);
        checkOutput("advance_l3", 2'd3, 1'b1, 4'b1111, 1'b0);
        expectRunNextEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000);
        checkOutput("fired_immediate", 2'd3, 1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("fired_hold", 2'd3, 1'b0, 4'b0000, 1'b1);

        // Delay of 3 valid samples spaced two cycles apart, matches ignored meanwhile.
        configure(4'b0001, 8'd0, {16'd0, 16'd0, 16'd0, 16'd3});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("delay_armed", 2'd0, 1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        checkOutput("delay_entered", 2'd0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("delay_after_2", 2'd0, 1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        expectRunNextEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("delay_fired", 2'd0, 1'b0, 4'b0000, 1'b1);

        // Simultaneous matches: stage 1 (delay 5) beats stage 2 (delay 0) and stage 0's advance.
        configure(4'b0110, 8'd0, {16'd0, 16'd0, 16'd5, 16'd0});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0111);
        checkOutput("simul_delay", 2'd0, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("simul_after_4", 2'd0, 1'b1, 4'b0000, 1'b0);
        expectRunNextEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("simul_fired", 2'd0, 1'b0, 4'b0000, 1'b1);

        // Saturation and smpl_valid gating with all stages non-start.
        configure(4'b0000, 8'd0, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        checkOutput("gate_no_valid", 2'd0, 1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("sat_l1_multi", 2'd1, 1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        checkOutput("sat_l3", 2'd3, 1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        checkOutput("sat_hold", 2'd3, 1'b1, 4'b1111, 1'b0);

        // Abort the delay with arm, then fire and re-arm from FIRED.
        configure(4'b0001, 8'd0, {16'd0, 16'd0, 16'd0, 16'd3});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000);
        checkOutput("abort_rearmed", 2'd0, 1'b1, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("abort_no_run", 2'd0, 1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        expectRunNextEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        checkOutput("abort_then_fired", 2'd0, 1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("rearm_from_fired", 2'd0, 1'b1, 4'b1111, 1'b0);

        // Reset mid-operation beats arm.
        configure(4'b0000, 8'd0, 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        checkOutput("pre_reset_l1", 2'd1, 1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("mid_reset", 2'd0, 1'b0, 4'b0000, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        vectors++;
        if (runQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL run_missing: got %0d expected pulses never seen, want 0", runQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
